mux_2x1_arbiter: RTL and testbench
==================================

Name: mux_2x1_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 multiplexed datapath between two requesters (x1 side, x2 side).
- Decides which source drives the mux select s, and grants bursts of up to MAX_BURST beats.
- Registers the selected word into a single-entry output stage with a valid/ready handshake.
- Sits between two producer blocks and one downstream consumer.

Parameters:
- WIDTH, 8, data width of x1, x2 and f.
- MAX_BURST, 4, max beats one requester may transfer while the other is requesting (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req1  in  1  requester 1 has a valid word on x1.
- x1  in  WIDTH  requester 1 data; held stable while req1=1 and ack1=0.
- ack1  out  1  combinational; x1 consumed this cycle.
- gnt1  out  1  registered; requester 1 owns the mux.
- req2  in  1  requester 2 has a valid word on x2.
- x2  in  WIDTH  requester 2 data; same rules as x1.
- ack2  out  1  combinational; x2 consumed this cycle.
- gnt2  out  1  registered; requester 2 owns the mux.
- s  out  1  registered mux select: 0 = x1, 1 = x2; equals gnt2.
- f  out  WIDTH  registered output data.
- f_valid  out  1  f holds an unconsumed word.
- f_ready  in  1  consumer accepts f when f_valid=1.

Behaviour:
- Reset values (async, while rst=1): state=IDLE, gnt1=0, gnt2=0, s=0, f=0, f_valid=0, beat count=0, last_served=2 (so requester 1 wins the first tie).
- States:
  - IDLE: no grant.
  - G1: gnt1=1, s=0.
  - G2: gnt2=1, s=1.
  - gnt1 and gnt2 are never both 1.
- Arbitration in IDLE, applied at the next edge:
  - req1 only -> G1.
  - req2 only -> G2.
  - Both -> the requester other than last_served.
  - Neither -> stay in IDLE.
  - Minimum request-to-grant latency is 1 cycle.
- Output stage:
  - space = !f_valid | f_ready.
  - In Gi: acki = reqi & space (combinational).
  - On acki: f <= xi, f_valid <= 1, count <= count+1, last_served <= i.
  - If f_ready & f_valid and no ack: f_valid <= 0; f holds its value.
  - Simultaneous drain and load: f_valid stays 1 and f takes the new word (full throughput, one beat per cycle).
- Leaving Gi (evaluated each cycle, other = j):
  - reqi=0: go to Gj if reqj, else IDLE; count <= 0. There is no IDLE bubble when switching.
  - acki and count+1 == MAX_BURST and reqj: go to Gj, count <= 0 (forced hand-off).
  - acki and count+1 == MAX_BURST and !reqj: stay in Gi, count <= 0.
  - Otherwise: stay in Gi.
- Count is ceil(log2(MAX_BURST+1)) bits and never exceeds MAX_BURST-1 after an edge.
- MAX_BURST=1 gives strict per-beat alternation under contention.
- Backpressure: f_ready=0 with f_valid=1 gives ack=0. The grant is held and count is frozen, while the requester keeps reqi and xi stable.
- If reqi drops while stalled, the grant is released per the rules above and f is unaffected.
- No beat is lost or duplicated: each acki pulse produces exactly one f_valid&f_ready transfer later, in order.
- A req on the non-granted side has no effect until arbitration; its ack stays 0.
- Reset mid-burst: everything returns to the reset values immediately. A word in f is discarded and requesters must re-request.

Test Plan:
- Reset: assert rst mid-transfer with f_valid=1 -> gnt1=gnt2=0, s=0, f=0, f_valid=0 asynchronously, before the next clk edge.
- Single requester: req1=1 with x1=0x11,0x22,0x33 on successive acks, f_ready=1 -> gnt1 one cycle after req1; f shows 0x11,0x22,0x33 on consecutive cycles; s=0 throughout.
- Contention, MAX_BURST=4: req1 and req2 held high from reset, f_ready=1 -> G1 for 4 beats, switch to G2 with no idle cycle, G2 for 4 beats, back to G1; s toggles every 4 beats.
- Tie-break: after requester 2 finishes last, both request at once from IDLE -> gnt1 wins; repeat with 1 last -> gnt2 wins.
- Backpressure: in G2 with x2=0xA5, f_ready=0 for 3 cycles -> f=0xA5, f_valid=1, ack2=0, count frozen. Raise f_ready -> 0xA5 accepted once, next x2 loaded the same cycle.
- Early release: in G1, drop req1 after 2 beats while req2=1 -> next cycle gnt2=1, s=1, count restarts at 0. With req2=0 instead -> IDLE, s=0.

Source files
------------

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: round-robin burst arbiter sharing a 2:1 mux into a one-entry valid/ready output stage
module mux_2x1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  output logic             ack1,
  output logic             gnt1,
  input  logic             req2,
  input  logic [WIDTH-1:0] x2,
  output logic             ack2,
  output logic             gnt2,
  output logic             s,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  input  logic             f_ready
);
  localparam int CW = $clog2(MAX_BURST + 1);
  // state bits double as the registered grants: bit0 = gnt1, bit1 = gnt2
  typedef enum logic [1:0] {IDLE = 2'b00, G1 = 2'b01, G2 = 2'b10} state_t;
  state_t           state_q, state_d, oth_st;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             fv_q, fv_d, last2_q, last2_d;
  logic             space, ack, own_req, oth_req, burst_end;
  assign space     = !fv_q || f_ready;
  assign ack1      = state_q == G1 && req1 && space;
  assign ack2      = state_q == G2 && req2 && space;
  assign ack       = ack1 || ack2;
  assign own_req   = state_q == G2 ? req2 : req1;
  assign oth_req   = state_q == G2 ? req1 : req2;
  assign oth_st    = state_q == G2 ? G1 : G2;
  assign burst_end = ack && (cnt_q + CW'(1) == CW'(MAX_BURST));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE)
      state_d = req1 && req2 ? (last2_q ? G1 : G2) : req1 ? G1 : req2 ? G2 : IDLE;
    else if (!own_req) begin
      state_d = oth_req ? oth_st : IDLE;
      cnt_d   = '0;
    end else if (burst_end) begin
      state_d = oth_req ? oth_st : state_q;
      cnt_d   = '0;
    end else if (ack)
      cnt_d = cnt_q + CW'(1);
    f_d     = ack ? (state_q == G2 ? x2 : x1) : f_q;
    fv_d    = ack || (fv_q && !f_ready);
    last2_d = ack ? state_q == G2 : last2_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      fv_q    <= 1'b0;
      last2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      fv_q    <= fv_d;
      last2_q <= last2_d;
    end
  assign gnt1    = state_q[0];
  assign gnt2    = state_q[1];
  assign s       = state_q[1];
  assign f       = f_q;
  assign f_valid = fv_q;
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb_mux_2x1_arbiter: directed and random checks against a behavioural grant/scoreboard model
module tb_mux_2x1_arbiter;
  localparam int W = 8, MB = 4;
  logic clk = 0, rst = 0, req1 = 0, req2 = 0, f_ready = 0;
  logic [W-1:0] x1 = '0, x2 = '0, f;
  logic ack1, gnt1, ack2, gnt2, s, f_valid;
  int checks = 0, errors = 0;
  int m_own, m_cnt, m_last;
  bit m_fv, la1, la2, n1, n2;
  logic [W-1:0] m_f;
  logic [W-1:0] sb[$];
  always #5 clk = ~clk;
  mux_2x1_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req1(req1), .x1(x1), .ack1(ack1), .gnt1(gnt1),
    .req2(req2), .x2(x2), .ack2(ack2), .gnt2(gnt2), .s(s), .f(f),
    .f_valid(f_valid), .f_ready(f_ready));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set(bit r1, bit r2, logic [W-1:0] a, logic [W-1:0] b, bit fr);
    req1 = r1; req2 = r2; x1 = a; x2 = b; f_ready = fr;
  endtask
  // called just after a falling edge; reset is raised and checked before the next rising edge
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_gnt1", gnt1, 0); chk("rst_gnt2", gnt2, 0); chk("rst_s", s, 0);
    chk("rst_f", f, 0); chk("rst_fv", f_valid, 0);
    m_own = 0; m_cnt = 0; m_last = 2; m_fv = 0; m_f = '0; la1 = 0; la2 = 0;
    sb.delete();
    set(0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
  endtask
  // check one cycle against the model, then advance the model and the clock
  task automatic cyc();
    bit e1, e2, sp, own_r, oth_r;
    logic [W-1:0] w;
    #1;
    sp = !m_fv || f_ready;
    e1 = m_own == 1 && req1 && sp;
    e2 = m_own == 2 && req2 && sp;
    chk("ack1", ack1, e1); chk("ack2", ack2, e2);
    chk("gnt1", gnt1, m_own == 1); chk("gnt2", gnt2, m_own == 2); chk("s", s, m_own == 2);
    chk("f_valid", f_valid, m_fv); chk("f", f, m_f);
    if (m_fv && f_ready) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("sb_order", f, sb.pop_front());
    end
    if (e1 || e2) begin
      w = e1 ? x1 : x2;
      sb.push_back(w);
      m_f = w; m_fv = 1; m_last = e1 ? 1 : 2; m_cnt++;
    end else if (f_ready) m_fv = 0;
    if (m_own == 0) m_own = req1 && req2 ? 3 - m_last : req1 ? 1 : req2 ? 2 : 0;
    else begin
      own_r = m_own == 1 ? req1 : req2;
      oth_r = m_own == 1 ? req2 : req1;
      if (!own_r) begin
        m_own = oth_r ? 3 - m_own : 0; m_cnt = 0;
      end else if ((e1 || e2) && m_cnt == MB) begin
        m_cnt = 0;
        if (oth_r) m_own = 3 - m_own;
      end
    end
    la1 = e1; la2 = e2;
    @(posedge clk); @(negedge clk);
  endtask
  initial begin
    do_reset();
    // single requester streaming
    set(1, 0, 8'h11, 0, 1); cyc();
    chk("single_gnt", gnt1, 1);
    cyc(); x1 = 8'h22;
    chk("single_f11", f, 8'h11); cyc(); x1 = 8'h33;
    chk("single_f22", f, 8'h22); cyc();
    chk("single_f33", f, 8'h33); req1 = 0; cyc(); cyc();
    // contention: 4-beat bursts alternating without an idle cycle
    do_reset();
    set(1, 1, 0, 0, 1); cyc();
    for (int k = 0; k < 12; k++) begin
      x1 = W'(k); x2 = W'(8'h80 + k);
      #1;
      chk("cont_s", s, (k / 4) % 2);
      chk("cont_gnt1", gnt1, (k / 4) % 2 == 0);
      cyc();
    end
    // tie-break follows last served
    do_reset();
    set(1, 0, 8'h01, 0, 1); cyc(); cyc();
    set(0, 0, 0, 0, 1); cyc();
    set(1, 1, 8'h02, 8'h03, 1); cyc();
    chk("tie_last1_gnt2", gnt2, 1);
    cyc();
    set(0, 0, 0, 0, 1); cyc();
    set(1, 1, 8'h04, 8'h05, 1); cyc();
    chk("tie_last2_gnt1", gnt1, 1);
    set(0, 0, 0, 0, 1); cyc(); cyc();
    // backpressure holds data, grant and beat count
    do_reset();
    set(0, 1, 0, 8'hA5, 0); cyc(); cyc();
    x2 = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ack2", ack2, 0);
      cyc();
      chk("bp_f", f, 8'hA5); chk("bp_fv", f_valid, 1);
    end
    f_ready = 1;
    #1 chk("bp_release_ack2", ack2, 1);
    cyc();
    chk("bp_next_f", f, 8'h5A);
    req1 = 1; x2 = 8'hC1; cyc(); x2 = 8'hC2; cyc();
    chk("bp_frozen_cnt_handoff", gnt1, 1);
    set(0, 0, 0, 0, 1); cyc(); cyc();
    // early release with the other side requesting, then with nobody requesting
    do_reset();
    set(1, 1, 8'h31, 8'h41, 1); cyc(); cyc(); x1 = 8'h32; cyc();
    req1 = 0; cyc();
    chk("early_gnt2", gnt2, 1); chk("early_s", s, 1);
    req1 = 1;
    for (int k = 0; k < 6; k++) begin x1 = W'(8'h50 + k); x2 = W'(8'h60 + k); cyc(); end
    do_reset();
    set(1, 0, 8'h71, 0, 1); cyc(); cyc(); x1 = 8'h72; cyc();
    req1 = 0; cyc();
    chk("early_idle_s", s, 0); chk("early_idle_gnt1", gnt1, 0);
    // asynchronous reset while a word sits in f
    set(1, 0, 8'h77, 0, 0); cyc(); cyc();
    chk("mid_fv", f_valid, 1);
    do_reset();
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      n1 = $urandom_range(3) != 0;
      n2 = $urandom_range(3) != 0;
      if (!(req1 && !la1 && n1)) x1 = W'($urandom);
      if (!(req2 && !la2 && n2)) x2 = W'($urandom);
      req1 = n1; req2 = n2;
      f_ready = $urandom_range(2) != 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
